// File: rtl/ex_pkg.sv
// Shared types for the execute operand stage: ALU opcodes, buffered entry layout
// and the writeback forwarding helper.
package ex_pkg;

    localparam int unsigned EX_DEPTH   = 2;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned ALU_OP_W   = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRA = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_t;

    typedef struct packed {
        alu_op_t             aluop;
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic [REG_AW-1:0]   rd;
        logic                cmp;
        logic                cmp_unsigned;
        logic [REG_AW-1:0]   rs1_addr;
        logic [REG_AW-1:0]   rs2_addr;
        logic                a_is_reg;
        logic                b_is_reg;
    } ex_entry_t;

    // Replace register-sourced operands that match a live, non-x0 writeback.
    function automatic ex_entry_t fwd_entry(input ex_entry_t e,
                                            input logic wb_v,
                                            input logic [REG_AW-1:0] wb_rd,
                                            input logic [XLEN-1:0] wb_d);
        ex_entry_t r;
        r = e;
        if (wb_v && (wb_rd != REG_AW'(0))) begin
            if (e.a_is_reg && (e.rs1_addr == wb_rd)) r.a = wb_d;
            if (e.b_is_reg && (e.rs2_addr == wb_rd)) r.b = wb_d;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_operand_buf.sv
// Two-entry FIFO of decoded ALU entries; head is slot 0. Held entries are
// refreshed from the forwarding port every cycle.
module ex_operand_buf
    import ex_pkg::*;
#(
    parameter int unsigned DEPTH = EX_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  ex_entry_t         entry_i,
    input  logic              fwd_valid_i,
    input  logic [REG_AW-1:0] fwd_rd_i,
    input  logic [XLEN-1:0]   fwd_data_i,
    output ex_entry_t         head_o,
    output logic              valid_o,
    output logic              ready_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    ex_entry_t  e0_q, e0_d, e1_q, e1_d;
    ex_entry_t  e0_fwd_c, e1_fwd_c, in_fwd_c;
    logic [1:0] count_q, count_d;
    logic       valid_q, ready_q;

    always_comb begin
        e0_fwd_c = e0_q;
        e1_fwd_c = e1_q;
        if (count_q != 2'd0) e0_fwd_c = fwd_entry(e0_q, fwd_valid_i, fwd_rd_i, fwd_data_i);
        if (count_q == FULL) e1_fwd_c = fwd_entry(e1_q, fwd_valid_i, fwd_rd_i, fwd_data_i);
        in_fwd_c = fwd_entry(entry_i, fwd_valid_i, fwd_rd_i, fwd_data_i);

        e0_d    = e0_fwd_c;
        e1_d    = e1_fwd_c;
        count_d = count_q;

        // Slot 0 is left untouched when the buffer drains so outputs keep last values.
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = in_fwd_c;
                    else                 e1_d = in_fwd_c;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == FULL) e0_d = e1_fwd_c;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == FULL) begin
                        e0_d = e1_fwd_c;
                        e1_d = in_fwd_c;
                    end else begin
                        e0_d = in_fwd_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
            ready_q <= (count_d < FULL);
        end
    end

    assign head_o  = e0_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/ex_operand_stage.sv
// Execute-stage front end: funct3/funct7 to ALU opcode, operand muxes and a
// two-entry buffer toward the ALU. Define EX_FORWARD_EN for writeback forwarding.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int unsigned DEPTH = EX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_rs1_v,
    input  logic [31:0] id_rs2_v,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7b5,
    input  logic        id_is_rtype,
    input  logic        id_a_sel,
    input  logic        id_b_sel,
    input  logic        id_force_add,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [2:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_rd,
    output logic        ex_cmp,
    output logic        ex_cmp_unsigned
);

    alu_op_t          aluop_c;
    logic             cmp_c, cmpu_c;
    logic [XLEN-1:0]  rs1_val_c, rs2_val_c;
    ex_entry_t        entry_c, head;
    logic             fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;

    // Decode to ALU opcode; SLT/SLTU reuse subtract and flag the compare.
    always_comb begin
        aluop_c = ALU_ADD;
        cmp_c   = 1'b0;
        cmpu_c  = 1'b0;
        if (!id_force_add) begin
            case (id_funct3)
                3'b000: aluop_c = (id_is_rtype && id_funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001: aluop_c = ALU_SLL;
                3'b010,
                3'b011: begin
                    aluop_c = ALU_SUB;
                    cmp_c   = 1'b1;
                    cmpu_c  = id_funct3[0];
                end
                3'b100: aluop_c = ALU_XOR;
                3'b101: aluop_c = id_funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110: aluop_c = ALU_OR;
                3'b111: aluop_c = ALU_AND;
                default: aluop_c = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        rs1_val_c = (id_rs1_addr == REG_AW'(0)) ? XLEN'(0) : id_rs1_v;
        rs2_val_c = (id_rs2_addr == REG_AW'(0)) ? XLEN'(0) : id_rs2_v;

        entry_c              = '0;
        entry_c.aluop        = aluop_c;
        entry_c.a            = id_a_sel ? id_pc  : rs1_val_c;
        entry_c.b            = id_b_sel ? id_imm : rs2_val_c;
        entry_c.rd           = id_rd_addr;
        entry_c.cmp          = cmp_c;
        entry_c.cmp_unsigned = cmpu_c;
        entry_c.rs1_addr     = id_rs1_addr;
        entry_c.rs2_addr     = id_rs2_addr;
        entry_c.a_is_reg     = !id_a_sel;
        entry_c.b_is_reg     = !id_b_sel;
    end

`ifdef EX_FORWARD_EN
    assign fwd_valid = wb_valid;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;
`else
    // Hazards are resolved by stalling decode; writeback is not observed here.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

    ex_operand_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (id_valid && id_ready),
        .pop_i       (ex_valid && ex_ready),
        .flush_i     (flush),
        .entry_i     (entry_c),
        .fwd_valid_i (fwd_valid),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .head_o      (head),
        .valid_o     (ex_valid),
        .ready_o     (id_ready)
    );

    assign ex_aluop        = head.aluop;
    assign ex_a            = head.a;
    assign ex_b            = head.b;
    assign ex_rd           = head.rd;
    assign ex_cmp          = head.cmp;
    assign ex_cmp_unsigned = head.cmp_unsigned;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed instructions with hand-computed
// ALU operands; a monitor checks every handshake-completed output in order.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_rs1_v, id_rs2_v, id_imm, id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_is_rtype, id_a_sel, id_b_sel, id_force_add;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [2:0]  ex_aluop;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_rd;
    logic        ex_cmp, ex_cmp_unsigned;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        cmp;
        logic        cmpu;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    ex_operand_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_rs1_v        (id_rs1_v),
        .id_rs2_v        (id_rs2_v),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rd_addr      (id_rd_addr),
        .id_imm          (id_imm),
        .id_pc           (id_pc),
        .id_funct3       (id_funct3),
        .id_funct7b5     (id_funct7b5),
        .id_is_rtype     (id_is_rtype),
        .id_a_sel        (id_a_sel),
        .id_b_sel        (id_b_sel),
        .id_force_add    (id_force_add),
        .flush           (flush),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_aluop        (ex_aluop),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_rd           (ex_rd),
        .ex_cmp          (ex_cmp),
        .ex_cmp_unsigned (ex_cmp_unsigned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic cmp, input logic cmpu);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.cmp = cmp; e.cmpu = cmpu;
        return e;
    endfunction

    // Monitor: compare every completed output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(ex_rd), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_aluop", 32'(ex_aluop), 32'(e.op));
                chk("pop_a", ex_a, e.a);
                chk("pop_b", ex_b, e.b);
                chk("pop_rd", 32'(ex_rd), 32'(e.rd));
                chk("pop_cmp", 32'({ex_cmp, ex_cmp_unsigned}), 32'({e.cmp, e.cmpu}));
            end
        end
    end

    task automatic set_instr(input logic [2:0] f3, input logic f7, input logic rtype,
                             input logic asel, input logic bsel, input logic fadd,
                             input logic [4:0] rs1a, input logic [31:0] rs1v,
                             input logic [4:0] rs2a, input logic [31:0] rs2v,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        id_funct3 = f3; id_funct7b5 = f7; id_is_rtype = rtype;
        id_a_sel = asel; id_b_sel = bsel; id_force_add = fadd;
        id_rs1_addr = rs1a; id_rs1_v = rs1v; id_rs2_addr = rs2a; id_rs2_v = rs2v;
        id_imm = imm; id_pc = pc; id_rd_addr = rd;
    endtask

    // Offer the current instruction until accepted; returns #1 after the accepting edge.
    task automatic send(input bit do_exp, input exp_t e);
        int n;
        n = 0;
        id_valid = 1'b1;
        @(negedge clk);
        while (!id_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!id_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: id_ready stuck at %0b, expected 1", id_ready);
        end else if (do_exp) begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        set_instr(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluop", 32'(ex_aluop), 32'd0);
        chk("rst_a", ex_a, 32'd0);
        chk("rst_b", ex_b, 32'd0);
        chk("rst_rd_cmp", 32'({ex_rd, ex_cmp, ex_cmp_unsigned}), 32'd0);
        step();

        // Streaming with ALU ready: back-to-back decode patterns.
        ex_ready = 1'b1;
        set_instr(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd7, 5'd2, 32'd3, 32'd0, 32'h100, 5'd4);
        send(1'b1, mk(3'b011, 32'd7, 32'd3, 5'd4, 1'b0, 1'b0));
        chk("latency_ex_valid", 32'(ex_valid), 32'd1);
        set_instr(3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h8000_0000, 5'd6, 32'd9, 32'd4, 32'h104, 5'd7);
        send(1'b1, mk(3'b010, 32'h8000_0000, 32'd4, 5'd7, 1'b0, 1'b0));
        set_instr(3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h8000_0000, 5'd6, 32'd9, 32'd4, 32'h108, 5'd8);
        send(1'b1, mk(3'b101, 32'h8000_0000, 32'd4, 5'd8, 1'b0, 1'b0));
        set_instr(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'd20, 5'd6, 32'd9, 32'hFFFF_FFF0, 32'h10C, 5'd9);
        send(1'b1, mk(3'b000, 32'd20, 32'hFFFF_FFF0, 5'd9, 1'b0, 1'b0));
        set_instr(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'h110, 5'd10);
        send(1'b1, mk(3'b011, 32'd1, 32'd2, 5'd10, 1'b1, 1'b1));
        set_instr(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 32'h114, 5'd11);
        send(1'b1, mk(3'b011, 32'd1, 32'd2, 5'd11, 1'b1, 1'b0));
        set_instr(3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd1, 5'd2, 32'd2, 32'h20, 32'h1000, 5'd12);
        send(1'b1, mk(3'b000, 32'h1000, 32'h20, 5'd12, 1'b0, 1'b0));
        set_instr(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, 5'd2, 32'h55, 32'd0, 32'h118, 5'd13);
        send(1'b1, mk(3'b100, 32'd0, 32'h55, 5'd13, 1'b0, 1'b0));
        set_instr(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hF0, 5'd0, 32'h1234, 32'd0, 32'h11C, 5'd14);
        send(1'b1, mk(3'b110, 32'hF0, 32'd0, 5'd14, 1'b0, 1'b0));
        set_instr(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hFF, 5'd2, 32'h0F, 32'd0, 32'h120, 5'd15);
        send(1'b1, mk(3'b111, 32'hFF, 32'h0F, 5'd15, 1'b0, 1'b0));
        set_instr(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd31, 32'h124, 5'd16);
        send(1'b1, mk(3'b001, 32'd1, 32'd31, 5'd16, 1'b0, 1'b0));
        repeat (3) step();
        chk("drain_ex_valid", 32'(ex_valid), 32'd0);
        chk("empty_holds_rd", 32'(ex_rd), 32'd16);

        // Back-pressure: third instruction stalls until the ALU drains.
        ex_ready = 1'b0;
        set_instr(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'd0, 32'h200, 5'd17);
        send(1'b1, mk(3'b100, 32'hA1, 32'hA2, 5'd17, 1'b0, 1'b0));
        set_instr(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hB1, 5'd2, 32'hB2, 32'd0, 32'h204, 5'd18);
        send(1'b1, mk(3'b110, 32'hB1, 32'hB2, 5'd18, 1'b0, 1'b0));
        set_instr(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hC1, 5'd2, 32'hC2, 32'd0, 32'h208, 5'd19);
        id_valid = 1'b1;
        @(negedge clk);
        chk("full_id_ready", 32'(id_ready), 32'd0);
        repeat (2) step();
        @(negedge clk);
        chk("full_still_stalled", 32'(id_ready), 32'd0);
        chk("held_head_a", ex_a, 32'hA1);
        chk("held_head_op", 32'(ex_aluop), 32'b100);
        step();
        ex_ready = 1'b1;
        send(1'b1, mk(3'b111, 32'hC1, 32'hC2, 5'd19, 1'b0, 1'b0));
        repeat (4) step();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Writeback forwarding onto a held head and at capture.
        ex_ready = 1'b0;
        set_instr(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h10, 5'd0, 32'd0, 32'd8, 32'h300, 5'd9);
`ifdef EX_FORWARD_EN
        send(1'b1, mk(3'b000, 32'hABCD, 32'd8, 5'd9, 1'b0, 1'b0));
`else
        send(1'b1, mk(3'b000, 32'h10, 32'd8, 5'd9, 1'b0, 1'b0));
`endif
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555;
        step();
        wb_valid = 1'b0;
        chk("fwd_rd0_ignored", ex_a, 32'h10);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
        step();
        wb_valid = 1'b0;
`ifdef EX_FORWARD_EN
        chk("fwd_held_a", ex_a, 32'hABCD);
`else
        chk("nofwd_held_a", ex_a, 32'h10);
`endif
        set_instr(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h3, 5'd6, 32'h66, 32'd0, 32'h304, 5'd20);
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h77;
`ifdef EX_FORWARD_EN
        send(1'b1, mk(3'b100, 32'h3, 32'h77, 5'd20, 1'b0, 1'b0));
`else
        send(1'b1, mk(3'b100, 32'h3, 32'h66, 5'd20, 1'b0, 1'b0));
`endif
        wb_valid = 1'b0;
        ex_ready = 1'b1;
        repeat (4) step();
        chk("fwd_drained", 32'(exp_q.size()), 32'd0);

        // Flush when full with decode offering, then flush discarding an accepted push.
        ex_ready = 1'b0;
        set_instr(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 32'h400, 5'd21);
        send(1'b0, mk(3'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
        send(1'b0, mk(3'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
        id_valid = 1'b1; flush = 1'b1;
        step();
        id_valid = 1'b0; flush = 1'b0;
        chk("flush_full_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_full_id_ready", 32'(id_ready), 32'd1);
        send(1'b0, mk(3'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
        id_valid = 1'b1; flush = 1'b1;
        step();
        id_valid = 1'b0; flush = 1'b0;
        chk("flush_push_ex_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_leak", 32'(ex_valid), 32'd0);

        // Asynchronous reset with two entries buffered.
        ex_ready = 1'b0;
        set_instr(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'd0, 32'h500, 5'd22);
        send(1'b0, mk(3'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
        send(1'b0, mk(3'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
        chk("pre_rst_a", ex_a, 32'h1234);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_ex_a", ex_a, 32'd0);
        chk("async_rst_id_ready", 32'(id_ready), 32'd1);
        step();
        rst = 1'b0;
        ex_ready = 1'b1;
        repeat (3) step();
        chk("post_rst_empty", 32'(ex_valid), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
